// File: rtl/lsu_memory.sv
// lsu_memory: byte-addressed word memory behind a valid/ready load/store port.
// Loads and stores of byte, half and word size; misaligned, reserved-size and
// out-of-range requests are rejected with rsp_error and never touch memory.
// Each accepted request gets a registered one-cycle response the next cycle.
// Build macro DMEM_CLEAR_ON_RESET_EN adds a CLEAR state that zeroes every
// word after reset, one word per cycle, before the port opens.
module lsu_memory #(
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic                  rsp_valid,
    output logic [31:0]           read_data,
    output logic                  rsp_error
);

    localparam int IDX_W     = ADDR_WIDTH - 2;
    localparam int IDX_W1    = IDX_W + 1;
    localparam int MEM_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_L = IDX_W1'(MEM_DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // NOTE: the storage array has no reset term; only the optional CLEAR sweep
    // zeroes it, so it can map onto RAM rather than resettable flops.
    logic [31:0] mem [MEM_DEPTH] = '{default: '0};

    logic [IDX_W-1:0]     word_idx;
    logic [1:0]           lane;
    logic [MEM_IDX_W-1:0] mem_idx;
    logic                 accept;
    logic                 req_err;
    logic [31:0]          cur_word;
    logic [31:0]          shifted;
    logic [31:0]          load_val;
    logic [31:0]          store_word;

    logic                 mem_we;
    logic [MEM_IDX_W-1:0] mem_widx;
    logic [31:0]          mem_wdata;

    logic                 clear_active;
    logic                 ready_state;
    logic [MEM_IDX_W-1:0] clr_idx;

    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_error_q, rsp_error_d;
    logic [31:0]          read_data_q, read_data_d;

    assign word_idx  = address[ADDR_WIDTH-1:2];
    assign lane      = address[1:0];
    assign mem_idx   = word_idx[MEM_IDX_W-1:0];
    assign req_ready = ready_state && !reset;
    assign accept    = req_valid && req_ready;

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam logic [MEM_IDX_W-1:0] LAST_IDX = MEM_IDX_W'(MEM_DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [MEM_IDX_W-1:0] clr_cnt_q, clr_cnt_d;

    assign clr_idx = clr_cnt_q;

    // Next state: sweep one word per cycle, open the port after the last index.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and infers a latch.
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clear_active = 1'b0;
        ready_state  = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_active = !reset;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: ready_state = 1'b1;
        endcase
    end

    // State register: reset always restarts the sweep from index 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end
`else
    assign clear_active = 1'b0;
    assign ready_state  = 1'b1;
    assign clr_idx      = '0;
`endif

    // Decode: legality check, load extraction/extension and store merge.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = lane[0];
            SZ_WORD: req_err = (lane != 2'b00);
            default: req_err = 1'b1;
        endcase
        if ({1'b0, word_idx} >= DEPTH_L) begin
            req_err = 1'b1;
        end

        cur_word = mem[mem_idx];
        shifted  = cur_word >> {lane, 3'b000};

        case (req_size)
            SZ_BYTE: load_val = req_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_val = req_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = cur_word;
        endcase

        store_word = cur_word;
        case (req_size)
            SZ_BYTE: store_word[{lane, 3'b000} +: 8]     = write_data[7:0];
            SZ_HALF: store_word[{lane[1], 4'b0000} +: 16] = write_data[15:0];
            default: store_word = write_data;
        endcase
    end

    // Write port: the clear sweep owns it; otherwise a legal accepted store.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = mem_idx;
        mem_wdata = store_word;
        if (clear_active) begin
            mem_we    = 1'b1;
            mem_widx  = clr_idx;
            mem_wdata = '0;
        end else if (accept && req_write && !req_err) begin
            mem_we = 1'b1;
        end
    end

    // Memory write at the accepting edge, visible to a load the next cycle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Response next state: data only for legal loads, zero otherwise.
    always_comb begin
        rsp_valid_d = accept;
        rsp_error_d = accept && req_err;
        read_data_d = (accept && !req_write && !req_err) ? load_val : 32'h0;
    end

    // Response registers: reset drops any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            read_data_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            read_data_q <= read_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign read_data = read_data_q;

endmodule

// File: doc/lsu_memory.md
LSU_MEMORY -- requirements
Module: lsu_memory

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, giving the number of 32-bit words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, giving the byte-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned, input, 1 bit: loads zero-extend when 1 and sign-extend when 0.
REQ-010 SHALL have port address, input, ADDR_WIDTH bits: byte address.
REQ-011 SHALL have port write_data, input, 32 bits: store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit: a response is present (one-cycle pulse).
REQ-013 SHALL have port read_data, output, 32 bits: extended load result.
REQ-014 SHALL have port rsp_error, output, 1 bit: the request was rejected.

Function
REQ-015 SHALL be a byte-addressed memory: word index = address[ADDR_WIDTH-1:2]; byte lane = address[1:0].
REQ-016 SHALL implement FSM states CLEAR and READY; req_ready = 1 only in READY.
REQ-017 SHALL treat a request as accepted when req_valid && req_ready; one request per cycle maximum.
REQ-018 SHALL assert rsp_valid exactly 1 cycle after acceptance, for 1 cycle; rsp_valid and read_data are registered and there is no response backpressure.
REQ-019 SHALL write a store byte-lane-selectively at the accepting edge:
  - byte: write_data[7:0] to lane address[1:0];
  - half: write_data[15:0] to lanes address[1]*2 and +1;
  - word: all lanes.
  Other lanes SHALL be unchanged.
REQ-020 SHALL return read_data = 0 for a store response.
REQ-021 SHALL, for a load, extract the addressed byte/half/word and extend to 32 bits per req_unsigned; req_unsigned SHALL be ignored for word loads.
REQ-022 SHALL flag an error when any of the following holds:
  - req_size = 11;
  - half access with address[0] = 1;
  - word access with address[1:0] != 0;
  - word index >= MEM_DEPTH.
REQ-023 SHALL, for an erroring request, perform no write and respond with rsp_error = 1 and read_data = 0; rsp_error = 0 otherwise.
REQ-024 SHALL return the stored data to a load accepted in cycle N+1 after a store to the same word accepted in cycle N (read-after-write, no stale data).
REQ-025 SHALL, in CLEAR, zero one word per cycle in index order 0 to MEM_DEPTH-1, then enter READY the cycle after index MEM_DEPTH-1 is written.
REQ-026 SHALL, during CLEAR, hold req_ready = 0 and ignore req_valid.

Reset
REQ-027 SHALL, while reset = 1 at a clock edge, force rsp_valid = 0, rsp_error = 0, read_data = 0 and the clear counter to 0, and drop any pending response.
REQ-028 SHALL, on reset, enter CLEAR (macro defined) or READY (macro undefined); reset asserted mid-CLEAR SHALL restart the sweep at index 0.
REQ-029 SHALL hold req_ready = 0 during any cycle in which reset = 1.

Configuration
REQ-030 SHALL, with DMEM_CLEAR_ON_RESET_EN defined, include the CLEAR state and counter; reset then zeroes all MEM_DEPTH words, taking MEM_DEPTH cycles.
REQ-031 SHALL, with DMEM_CLEAR_ON_RESET_EN undefined, omit the CLEAR state and counter; the block enters READY directly, contents are zero only at simulation start, and reset does not alter memory.

Verification
REQ-032 SHALL pass the clear sweep (macro defined): reset for 1 cycle -> req_ready = 0 for exactly 256 cycles, then 1; a word load at 0x3FC returns 0x00000000.
REQ-033 SHALL pass byte lanes: word store 0x11223344 at 0x10, byte store 0xAB at 0x12 -> word load at 0x10 returns 0x11AB3344; byte load at 0x12 returns 0xFFFFFFAB signed and 0x000000AB unsigned.
REQ-034 SHALL pass half extension: half store 0x8001 at 0x22 -> half load at 0x22 returns 0xFFFF8001 signed and 0x00008001 unsigned; half 0x0000 at 0x20 unchanged.
REQ-035 SHALL pass errors: word load at 0x02, half store at 0x05, size 11, and word load at 0x400 (MEM_DEPTH = 256) -> each gives rsp_error = 1 and read_data = 0, and memory is unchanged.
REQ-036 SHALL pass back-to-back traffic: store 0xDEADBEEF at 0x40 in cycle N, load 0x40 in cycle N+1 -> rsp_valid in cycles N+1 and N+2; the load returns 0xDEADBEEF.
REQ-037 SHALL pass reset mid-operation: load accepted, then reset asserted the next edge -> no rsp_valid; reset at clear index 100 -> the sweep restarts and req_ready rises 256 cycles after reset deasserts.
